// File: rtl/stack_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : stack_pkg                                             |
// | Brief    : Shared types and helpers for the LIFO stack.          |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package stack_pkg;

    localparam int STACK_DEFAULT_WIDTH = 9;

    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } stack_op_t;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : stack_mem                                             |
// | Brief    : Register array, one sync write port, one async read.  |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module stack_mem #(
    parameter int WIDTH   = 9,
    parameter int ENTRIES = 7,
    parameter int ADDR_W  = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] r_mem [ENTRIES];

    // Contents are intentionally not reset; occupancy tracking makes stale data unreachable.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/lifo_stack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : lifo_stack                                            |
// | Brief    : Parametrised LIFO with registered top, flags, errors. |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module lifo_stack
    import stack_pkg::*;
#(
    parameter int WIDTH        = STACK_DEFAULT_WIDTH,
    parameter int DEPTH        = 8,
    parameter int WRAP_ON_FULL = 0,
    parameter int CNT_W        = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    localparam int             c_ptr_w = (clog2(DEPTH-1) < 1) ? 1 : clog2(DEPTH-1);
    localparam bit             c_wrap  = (WRAP_ON_FULL != 0);
    localparam [c_ptr_w-1:0]   c_last  = c_ptr_w'(DEPTH-2);
    localparam [CNT_W-1:0]     c_depth = CNT_W'(DEPTH);
    localparam [CNT_W-1:0]     c_one   = CNT_W'(1);

    logic [WIDTH-1:0]   r_top;
    logic [CNT_W-1:0]   r_count;
    logic [c_ptr_w-1:0] r_ptr;
    logic               r_empty;
    logic               r_full;
    logic               r_ovf;
    logic               r_unf;

    stack_op_t          w_op;
    logic [WIDTH-1:0]   w_top_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [c_ptr_w-1:0] w_ptr_nxt;
    logic [c_ptr_w-1:0] w_ptr_inc;
    logic [c_ptr_w-1:0] w_ptr_dec;
    logic               w_we;
    logic               w_ovf;
    logic               w_unf;
    logic [WIDTH-1:0]   w_rd;

    // r_ptr is the next free slot; the entry just below the top sits at r_ptr-1.
    assign w_ptr_inc = (r_ptr == c_last) ? '0 : r_ptr + c_ptr_w'(1);
    assign w_ptr_dec = (r_ptr == '0) ? c_last : r_ptr - c_ptr_w'(1);

    stack_mem #(
        .WIDTH   (WIDTH),
        .ENTRIES (DEPTH-1),
        .ADDR_W  (c_ptr_w)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_ptr),
        .wdata (r_top),
        .raddr (w_ptr_dec),
        .rdata (w_rd)
    );

    // A combined request on an empty stack has nothing to replace, so it is a plain push.
    always_comb begin
        w_op = OP_NONE;
        if (push && pop) begin
            w_op = r_empty ? OP_PUSH : OP_REPLACE;
        end else if (push) begin
            w_op = OP_PUSH;
        end else if (pop) begin
            w_op = OP_POP;
        end
    end

    always_comb begin
        w_top_nxt = r_top;
        w_cnt_nxt = r_count;
        w_ptr_nxt = r_ptr;
        w_we      = 1'b0;
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        case (w_op)
            OP_PUSH: begin
                w_ovf = r_full;
                if (!r_full || c_wrap) begin
                    w_top_nxt = in;
                    // When full, the slot at r_ptr holds the oldest entry and is overwritten.
                    if (!r_empty) begin
                        w_we      = 1'b1;
                        w_ptr_nxt = w_ptr_inc;
                    end
                    if (!r_full) begin
                        w_cnt_nxt = r_count + c_one;
                    end
                end
            end
            OP_POP: begin
                if (r_empty) begin
                    w_unf = 1'b1;
                end else if (r_count == c_one) begin
                    w_top_nxt = '0;
                    w_cnt_nxt = '0;
                end else begin
                    w_top_nxt = w_rd;
                    w_ptr_nxt = w_ptr_dec;
                    w_cnt_nxt = r_count - c_one;
                end
            end
            OP_REPLACE: begin
                w_top_nxt = in;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_top   <= '0;
            r_count <= '0;
            r_ptr   <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_top   <= w_top_nxt;
            r_count <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_empty <= (w_cnt_nxt == '0);
            r_full  <= (w_cnt_nxt == c_depth);
            r_ovf   <= w_ovf;
            r_unf   <= w_unf;
        end
    end

    assign out       = r_top;
    assign count     = r_count;
    assign empty     = r_empty;
    assign full      = r_full;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_lifo_stack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_lifo_stack                                         |
// | Brief    : Directed bench for lifo_stack, reject and wrap modes. |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_lifo_stack;

    localparam int c_width = 9;
    localparam int c_depth = 4;
    localparam int c_cnt_w = $clog2(c_depth+1);

    logic               clk;
    logic               rst;
    logic               push;
    logic               pop;
    logic [c_width-1:0] din;

    logic [c_width-1:0] nw_out, wr_out;
    logic               nw_empty, wr_empty, nw_full, wr_full;
    logic [c_cnt_w-1:0] nw_count, wr_count;
    logic               nw_ovf, wr_ovf, nw_unf, wr_unf;

    int vectors;
    int miscompares;

    lifo_stack #(.WIDTH(c_width), .DEPTH(c_depth), .WRAP_ON_FULL(0)) u_nowrap (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .in(din),
        .out(nw_out), .empty(nw_empty), .full(nw_full), .count(nw_count),
        .overflow(nw_ovf), .underflow(nw_unf)
    );

    lifo_stack #(.WIDTH(c_width), .DEPTH(c_depth), .WRAP_ON_FULL(1)) u_wrap (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .in(din),
        .out(wr_out), .empty(wr_empty), .full(wr_full), .count(wr_count),
        .overflow(wr_ovf), .underflow(wr_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the edge.
    task automatic step(input logic r, input logic pu, input logic po, input logic [c_width-1:0] d);
        rst  = r;
        push = pu;
        pop  = po;
        din  = d;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic chk_both(input string tag, input logic [31:0] e_out, input logic [31:0] e_cnt);
        check({tag, ".nw.out"}, 32'(nw_out), e_out);
        check({tag, ".nw.cnt"}, 32'(nw_count), e_cnt);
        check({tag, ".wr.out"}, 32'(wr_out), e_out);
        check({tag, ".wr.cnt"}, 32'(wr_count), e_cnt);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 9'h000);

        // Reset state
        chk_both("rst", 32'h0, 32'd0);
        check("rst.empty", 32'(nw_empty), 32'd1);
        check("rst.full",  32'(nw_full),  32'd0);
        check("rst.ovf",   32'(nw_ovf),   32'd0);
        check("rst.unf",   32'(wr_unf),   32'd0);

        // 1: basic push/pop
        step(1'b0, 1'b1, 1'b0, 9'h011);
        step(1'b0, 1'b1, 1'b0, 9'h022);
        step(1'b0, 1'b1, 1'b0, 9'h033);
        chk_both("t1.push3", 32'h033, 32'd3);
        check("t1.empty", 32'(nw_empty), 32'd0);
        check("t1.full",  32'(nw_full),  32'd0);
        step(1'b0, 1'b0, 1'b1, 9'h000);
        chk_both("t1.pop1", 32'h022, 32'd2);
        step(1'b0, 1'b0, 1'b1, 9'h000);
        chk_both("t1.pop2", 32'h011, 32'd1);
        step(1'b0, 1'b0, 1'b1, 9'h000);
        chk_both("t1.pop3", 32'h000, 32'd0);
        check("t1.empty3", 32'(wr_empty), 32'd1);

        // 2: reject mode, back-to-back overflow
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, 9'(i));
        check("t2.full", 32'(nw_full), 32'd1);
        step(1'b0, 1'b1, 1'b0, 9'h0AA);
        check("t2.ovf1", 32'(nw_ovf), 32'd1);
        check("t2.out1", 32'(nw_out), 32'h004);
        check("t2.cnt1", 32'(nw_count), 32'd4);
        step(1'b0, 1'b1, 1'b0, 9'h0BB);
        check("t2.ovf2", 32'(nw_ovf), 32'd1);
        check("t2.out2", 32'(nw_out), 32'h004);
        step(1'b0, 1'b0, 1'b1, 9'h000);
        check("t2.ovf_drop", 32'(nw_ovf), 32'd0);
        check("t2.pop1", 32'(nw_out), 32'h003);
        step(1'b0, 1'b0, 1'b1, 9'h000);
        check("t2.pop2", 32'(nw_out), 32'h002);
        step(1'b0, 1'b0, 1'b1, 9'h000);
        check("t2.pop3", 32'(nw_out), 32'h001);
        step(1'b0, 1'b0, 1'b1, 9'h000);
        check("t2.pop4", 32'(nw_out), 32'h000);
        check("t2.cnt4", 32'(nw_count), 32'd0);

        // 3: wrap mode discards the oldest entry
        step(1'b1, 1'b0, 1'b0, 9'h000);
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, 9'(i));
        check("t3.ovf0", 32'(wr_ovf), 32'd0);
        step(1'b0, 1'b1, 1'b0, 9'h005);
        check("t3.ovf", 32'(wr_ovf), 32'd1);
        check("t3.out", 32'(wr_out), 32'h005);
        check("t3.cnt", 32'(wr_count), 32'd4);
        check("t3.full", 32'(wr_full), 32'd1);
        step(1'b0, 1'b0, 1'b1, 9'h000);
        check("t3.ovf_drop", 32'(wr_ovf), 32'd0);
        check("t3.pop1", 32'(wr_out), 32'h004);
        step(1'b0, 1'b0, 1'b1, 9'h000);
        check("t3.pop2", 32'(wr_out), 32'h003);
        step(1'b0, 1'b0, 1'b1, 9'h000);
        check("t3.pop3", 32'(wr_out), 32'h002);
        step(1'b0, 1'b0, 1'b1, 9'h000);
        check("t3.pop4", 32'(wr_out), 32'h000);
        check("t3.empty", 32'(wr_empty), 32'd1);

        // 4: empty-stack edges (reject instance also drained: 1..4 pushed, 4 popped)
        step(1'b0, 1'b0, 1'b1, 9'h000);
        check("t4.unf.nw", 32'(nw_unf), 32'd1);
        check("t4.unf.wr", 32'(wr_unf), 32'd1);
        chk_both("t4.unf", 32'h000, 32'd0);
        step(1'b0, 1'b0, 1'b0, 9'h000);
        check("t4.unf_drop", 32'(nw_unf), 32'd0);
        step(1'b0, 1'b1, 1'b1, 9'h1FF);
        chk_both("t4.pp", 32'h1FF, 32'd1);
        check("t4.pp.unf", 32'(nw_unf), 32'd0);

        // 5: replace-top, also at full
        step(1'b1, 1'b0, 1'b0, 9'h000);
        step(1'b0, 1'b1, 1'b0, 9'h010);
        step(1'b0, 1'b1, 1'b0, 9'h020);
        step(1'b0, 1'b1, 1'b1, 9'h155);
        chk_both("t5.rep", 32'h155, 32'd2);
        step(1'b0, 1'b0, 1'b1, 9'h000);
        chk_both("t5.pop", 32'h010, 32'd1);
        step(1'b0, 1'b1, 1'b0, 9'h020);
        step(1'b0, 1'b1, 1'b0, 9'h030);
        step(1'b0, 1'b1, 1'b0, 9'h040);
        step(1'b0, 1'b1, 1'b1, 9'h0AB);
        chk_both("t5.repfull", 32'h0AB, 32'd4);
        check("t5.ovf.nw", 32'(nw_ovf), 32'd0);
        check("t5.ovf.wr", 32'(wr_ovf), 32'd0);
        step(1'b0, 1'b0, 1'b1, 9'h000);
        chk_both("t5.popfull", 32'h030, 32'd3);

        // 6: reset beats push in the same cycle
        step(1'b1, 1'b1, 1'b0, 9'h0F0);
        chk_both("t6.rst", 32'h000, 32'd0);
        check("t6.empty", 32'(nw_empty), 32'd1);
        check("t6.ovf",   32'(nw_ovf),   32'd0);
        step(1'b0, 1'b1, 1'b0, 9'h00C);
        chk_both("t6.push", 32'h00C, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
